// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Shared ALU function codes, request opcodes and sequencer states.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [2:0] C_FUNC_ADD   = 3'b000;
    localparam logic [2:0] C_FUNC_SUB   = 3'b001;
    localparam logic [2:0] C_FUNC_NAND  = 3'b010;
    localparam logic [2:0] C_FUNC_INC   = 3'b011;
    localparam logic [2:0] C_FUNC_PASSA = 3'b100;
    localparam logic [2:0] C_FUNC_PASSB = 3'b101;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_NAND  = 3'b010,
        OP_INC   = 3'b011,
        OP_PASSA = 3'b100,
        OP_PASSB = 3'b101,
        OP_MUL   = 3'b110,
        OP_CMPEQ = 3'b111
    } req_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MUL_LOOP = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer_if
// Brief    : Request/response handshake bundle of the ALU op sequencer.
//            rsp_ovf exists only when ALU_SEQ_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_err;
`ifdef ALU_SEQ_OVF_EN
    logic             rsp_ovf;
`endif

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
`ifdef ALU_SEQ_OVF_EN
        , input rsp_ovf
`endif
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
`ifdef ALU_SEQ_OVF_EN
        , output rsp_ovf
`endif
    );

endinterface
`default_nettype wire

// File: rtl/alu_seq_ovf_detect.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ovf_detect
// Brief    : Combinational two's-complement overflow check for add / subtract,
//            driven by the operand and result sign bits only.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ovf_detect (
    input  wire  a_msb,
    input  wire  b_msb,
    input  wire  res_msb,
    input  wire  is_sub,
    output logic ovf
);
    logic w_b_eff;

    // Subtraction adds the negated B, so its effective sign is inverted
    assign w_b_eff = b_msb ^ is_sub;
    assign ovf     = (a_msb == w_b_eff) && (res_msb != a_msb);

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Multi-cycle controller for the MY-P0 ALU; synthesizes MUL and
//            CMPEQ on top of the native functions. Option: ALU_SEQ_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int MUL_MAX_ITER = 255,
    parameter int CNT_W        = 8
) (
    input  wire              clk,
    input  wire              rst_n,
    alu_op_sequencer_if.slave bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_func,
    input  wire  [WIDTH-1:0] alu_out
);

    state_e           r_state,    w_state_nxt;
    req_op_e          r_op,       w_op_nxt;
    logic             r_b_over,   w_b_over_nxt;
    logic             r_b_zero,   w_b_zero_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [WIDTH-1:0] r_alu_a,    w_alu_a_nxt;
    logic [WIDTH-1:0] r_alu_b,    w_alu_b_nxt;
    logic [2:0]       r_alu_func, w_alu_func_nxt;
    logic [WIDTH-1:0] r_data,     w_data_nxt;
    logic             r_zero,     w_zero_nxt;
    logic             r_err,      w_err_nxt;
    logic             w_capture;

`ifdef ALU_SEQ_OVF_EN
    logic             r_ovf, w_ovf_nxt;
    logic             w_ovf;
    logic [WIDTH-1:0] w_ovf_b;

    // INC adds an implicit +1 rather than operand B
    assign w_ovf_b = (r_alu_func == C_FUNC_INC) ? WIDTH'(1) : r_alu_b;

    alu_seq_ovf_detect u_ovf_detect (
        .a_msb   (r_alu_a[WIDTH-1]),
        .b_msb   (w_ovf_b[WIDTH-1]),
        .res_msb (alu_out[WIDTH-1]),
        .is_sub  (r_alu_func == C_FUNC_SUB),
        .ovf     (w_ovf)
    );

    assign bus.rsp_ovf = r_ovf;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_b_over_nxt   = r_b_over;
        w_b_zero_nxt   = r_b_zero;
        w_cnt_nxt      = r_cnt;
        w_alu_a_nxt    = r_alu_a;
        w_alu_b_nxt    = r_alu_b;
        w_alu_func_nxt = r_alu_func;
        w_data_nxt     = r_data;
        w_err_nxt      = r_err;
        w_capture      = 1'b0;
`ifdef ALU_SEQ_OVF_EN
        w_ovf_nxt      = r_ovf;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_op_nxt     = req_op_e'(bus.req_op);
                    w_b_over_nxt = (bus.req_b > WIDTH'(MUL_MAX_ITER));
                    w_b_zero_nxt = (bus.req_b == '0);
                    w_alu_a_nxt  = bus.req_a;
                    w_alu_b_nxt  = bus.req_b;
                    w_state_nxt  = ST_EXEC;
                    case (req_op_e'(bus.req_op))
                        OP_CMPEQ: w_alu_func_nxt = C_FUNC_SUB;
                        OP_MUL: begin
                            // Accumulate A into a zeroed operand B times
                            w_alu_a_nxt    = '0;
                            w_alu_b_nxt    = bus.req_a;
                            w_alu_func_nxt = C_FUNC_ADD;
                            w_cnt_nxt      = bus.req_b[CNT_W-1:0];
                        end
                        default: w_alu_func_nxt = bus.req_op;
                    endcase
                end
            end
            ST_EXEC: begin
                if (r_op == OP_MUL) begin
`ifdef ALU_SEQ_OVF_EN
                    w_ovf_nxt = 1'b0;
`endif
                    if (r_b_over || r_b_zero) begin
                        w_err_nxt   = r_b_over;
                        w_data_nxt  = '0;
                        w_capture   = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_MUL_LOOP;
                    end
                end else begin
                    if (r_op == OP_CMPEQ) begin
                        w_data_nxt    = '0;
                        w_data_nxt[0] = (alu_out == '0);
                    end else begin
                        w_data_nxt = alu_out;
                    end
`ifdef ALU_SEQ_OVF_EN
                    w_ovf_nxt = (r_op inside {OP_ADD, OP_INC, OP_SUB, OP_CMPEQ}) && w_ovf;
`endif
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_MUL_LOOP: begin
                w_alu_a_nxt = alu_out;
                w_cnt_nxt   = r_cnt - CNT_W'(1);
`ifdef ALU_SEQ_OVF_EN
                w_ovf_nxt   = r_ovf | w_ovf;
`endif
                if (r_cnt == CNT_W'(1)) begin
                    w_data_nxt  = alu_out;
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_err_nxt      = 1'b0;
                    w_alu_func_nxt = C_FUNC_PASSA;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // rsp_zero only tracks rsp_data when a new result is captured
        w_zero_nxt = w_capture ? (w_data_nxt == '0) : r_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_PASSA;
            r_b_over   <= 1'b0;
            r_b_zero   <= 1'b0;
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_func <= C_FUNC_PASSA;
            r_data     <= '0;
            r_zero     <= 1'b0;
            r_err      <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            r_ovf      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_b_over   <= w_b_over_nxt;
            r_b_zero   <= w_b_zero_nxt;
            r_cnt      <= w_cnt_nxt;
            r_alu_a    <= w_alu_a_nxt;
            r_alu_b    <= w_alu_b_nxt;
            r_alu_func <= w_alu_func_nxt;
            r_data     <= w_data_nxt;
            r_zero     <= w_zero_nxt;
            r_err      <= w_err_nxt;
`ifdef ALU_SEQ_OVF_EN
            r_ovf      <= w_ovf_nxt;
`endif
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_data  = r_data;
    assign bus.rsp_zero  = r_zero;
    assign bus.rsp_err   = r_err;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_func      = r_alu_func;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Self-checking bench: directed vector table, reset-abort sequence
//            and random ops against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_func;
    int          n_checks = 0;
    int          n_errors = 0;

    alu_op_sequencer_if #(.WIDTH(32)) bus ();

    alu_op_sequencer #(.WIDTH(32), .MUL_MAX_ITER(255), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_func (alu_func),
        .alu_out  (alu_out)
    );

    // MY-P0 ALU behaviour
    always_comb begin
        case (alu_func)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = ~(alu_a & alu_b);
            3'b011:  alu_out = alu_a + 32'd1;
            3'b100:  alu_out = alu_a;
            3'b101:  alu_out = alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_data;
        logic        e_zero;
        logic        e_err;
        logic        e_ovf;
        int          e_lat;
        int          hold;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic add_ovf(input logic [31:0] x, input logic [31:0] y);
        longint s;
        s = longint'($signed(x)) + longint'($signed(y));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic sub_ovf(input logic [31:0] x, input logic [31:0] y);
        longint s;
        s = longint'($signed(x)) - longint'($signed(y));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Reference: result, error, overflow and latency straight from the op rules
    task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] data, output logic err, output logic ovf,
                             output int lat);
        logic [63:0] prod;
        logic [31:0] acc;
        data = 32'd0; err = 1'b0; ovf = 1'b0; lat = 2;
        case (op)
            3'd0: begin data = a + b;  ovf = add_ovf(a, b); end
            3'd1: begin data = a - b;  ovf = sub_ovf(a, b); end
            3'd2: data = ~(a & b);
            3'd3: begin data = a + 1;  ovf = add_ovf(a, 32'd1); end
            3'd4: data = a;
            3'd5: data = b;
            3'd6: begin
                if (b > 32'd255) begin
                    err = 1'b1;
                end else begin
                    prod = {32'd0, a} * {32'd0, b};
                    data = prod[31:0];
                    acc  = 32'd0;
                    for (int k = 0; k < int'(b); k++) begin
                        ovf = ovf | add_ovf(acc, a);
                        acc = acc + a;
                    end
                    if (b != 32'd0) lat = 2 + int'(b);
                end
            end
            default: begin data = (a == b) ? 32'd1 : 32'd0; ovf = sub_ovf(a, b); end
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_data, input logic e_zero, input logic e_err,
                          input logic e_ovf, input int e_lat, input int hold);
        int lat;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("req_ready_busy", bus.req_ready, 0);
        lat = 1;
        while (!bus.rsp_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, e_lat);
        if (bus.rsp_valid) begin
            check("rsp_data", bus.rsp_data, e_data);
            check("rsp_zero", bus.rsp_zero, e_zero);
            check("rsp_err", bus.rsp_err, e_err);
`ifdef ALU_SEQ_OVF_EN
            check("rsp_ovf", bus.rsp_ovf, e_ovf);
`else
            if (e_ovf) begin end
`endif
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check("hold_valid", bus.rsp_valid, 1);
                check("hold_data", bus.rsp_data, e_data);
                check("hold_zero", bus.rsp_zero, e_zero);
                check("hold_ready", bus.req_ready, 0);
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b0;
            check("valid_clear", bus.rsp_valid, 0);
            check("ready_after_hs", bus.req_ready, 1);
            check("err_clear", bus.rsp_err, 0);
            check("func_passa", alu_func, 3'b100);
        end
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, e_data;
        logic        e_err, e_ovf;
        int          e_lat;
        bit          seen_valid;

        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;

        //            op    a             b             data          z     e     ovf   lat  hold
        tbl[0]  = '{3'd0, 32'h7,        32'h5,        32'hC,        1'b0, 1'b0, 1'b0, 2,   0};
        tbl[1]  = '{3'd1, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b0, 1'b0, 2,   0};
        tbl[2]  = '{3'd7, 32'h1234,     32'h1234,     32'h1,        1'b0, 1'b0, 1'b0, 2,   0};
        tbl[3]  = '{3'd7, 32'h3,        32'h4,        32'h0,        1'b1, 1'b0, 1'b0, 2,   0};
        tbl[4]  = '{3'd6, 32'd13,       32'd10,       32'd130,      1'b0, 1'b0, 1'b0, 12,  0};
        tbl[5]  = '{3'd6, 32'd9,        32'd0,        32'h0,        1'b1, 1'b0, 1'b0, 2,   0};
        tbl[6]  = '{3'd6, 32'd5,        32'd256,      32'h0,        1'b1, 1'b1, 1'b0, 2,   1};
        tbl[7]  = '{3'd3, 32'hFFFF_FFFF, 32'h0,       32'h0,        1'b1, 1'b0, 1'b0, 2,   5};
        tbl[8]  = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0, 2, 0};
        tbl[9]  = '{3'd4, 32'hDEAD_BEEF, 32'h1,       32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 2,   0};
        tbl[10] = '{3'd5, 32'h55,       32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 2,   0};
        tbl[11] = '{3'd6, 32'hFFFF_FFFF, 32'd255,     32'hFFFF_FF01, 1'b0, 1'b0, 1'b0, 257, 0};
        tbl[12] = '{3'd0, 32'h7FFF_FFFF, 32'h1,       32'h8000_0000, 1'b0, 1'b0, 1'b1, 2,   0};
        tbl[13] = '{3'd1, 32'h8000_0000, 32'h1,       32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 2,   0};
        tbl[14] = '{3'd6, 32'h4000_0000, 32'd4,       32'h0,        1'b1, 1'b0, 1'b1, 6,   0};
        tbl[15] = '{3'd6, 32'd3,        32'd1,        32'd3,        1'b0, 1'b0, 1'b0, 3,   2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_zero", bus.rsp_zero, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_func", alu_func, 3'b100);
`ifdef ALU_SEQ_OVF_EN
        check("rst_rsp_ovf", bus.rsp_ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e_data, tbl[i].e_zero,
                   tbl[i].e_err, tbl[i].e_ovf, tbl[i].e_lat, tbl[i].hold);
        end

        // Reset while MUL A=5, B=100 is iterating
        @(negedge clk);
        bus.req_op    = 3'd6;
        bus.req_a     = 32'd5;
        bus.req_b     = 32'd100;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midmul_busy", bus.req_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", bus.req_ready, 1);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_alu_func", alu_func, 3'b100);
        check("abort_alu_a", alu_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 110; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen_valid = 1'b1;
        end
        bus.rsp_ready = 1'b0;
        check("abort_no_rsp", seen_valid, 0);
        run_op(3'd0, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1'b0, 2, 0);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (op == 3'd6) ? 32'($urandom_range(0, 300)) : $urandom;
            if (op == 3'd7 && $urandom_range(0, 1) == 1) b = a;
            ref_model(op, a, b, e_data, e_err, e_ovf, e_lat);
            run_op(op, a, b, e_data, (e_data == 32'd0), e_err, e_ovf, e_lat,
                   int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller that owns the operand registers and function select of the MY-P0 32-bit ALU, which is instantiated beside it. It accepts one operation per valid/ready request and sequences the ALU for one or more cycles. It returns a result over a valid/ready response channel. It synthesizes MUL (repeated add) and CMPEQ (subtract, then zero test) on top of the six native ALU functions.

Parameters:
WIDTH, 32, datapath width; must equal the ALU width
MUL_MAX_ITER, 255, largest multiplier B accepted by MUL; larger values are rejected with error
CNT_W, 8, iteration counter width; requires 2^CNT_W > MUL_MAX_ITER

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept; high only in IDLE
req_op  in  3  000 ADD, 001 SUB, 010 NAND, 011 INC, 100 PASSA, 101 PASSB, 110 MUL, 111 CMPEQ
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
alu_a  out  WIDTH  registered ALU operand A
alu_b  out  WIDTH  registered ALU operand B
alu_func  out  3  registered ALU function select; only 000-101 are ever driven
alu_out  in  WIDTH  combinational ALU result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  WIDTH  result; CMPEQ returns 1 or 0
rsp_zero  out  1  rsp_data == 0
rsp_err  out  1  MUL with B > MUL_MAX_ITER; rsp_data = 0

Behaviour:
- Reset (async assert, sync deassert use):
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_data = 0; rsp_zero = 0; rsp_err = 0.
  - alu_a = 0, alu_b = 0, alu_func = 3'b100 (PASSA); iteration counter = 0.
  - Reset mid-operation aborts the operation; no response is produced.
- States: IDLE, EXEC, MUL_LOOP, RESP.
- IDLE: on req_valid & req_ready, latch op, A and B, then go to EXEC.
  - Ops 000-101: alu_a = A, alu_b = B, alu_func = op.
  - CMPEQ: alu_func = 001 (SUB).
  - MUL: alu_a = 0 (accumulator), alu_b = A, alu_func = 000, counter = B[CNT_W-1:0].
- EXEC:
  - Non-MUL: capture alu_out into rsp_data. CMPEQ writes rsp_data = (alu_out == 0). Go to RESP.
  - MUL with B > MUL_MAX_ITER: rsp_err = 1, rsp_data = 0, go to RESP.
  - MUL with B == 0: rsp_data = 0, go to RESP.
  - Otherwise go to MUL_LOOP.
- MUL_LOOP: each cycle alu_a <= alu_out and counter decrements. When counter reaches 1, capture alu_out into rsp_data and go to RESP.
- Arithmetic: modulo 2^WIDTH wrap in all ops; MUL result is the low WIDTH bits of A*B.
- RESP: rsp_valid = 1. Response fields stay stable until rsp_ready. On handshake: go to IDLE, clear rsp_valid and rsp_err, return alu_func to PASSA.
- Latency (request handshake edge to rsp_valid):
  - 2 cycles for native ops, CMPEQ, B == 0, and error.
  - 2 + B cycles for MUL.
- Throughput: one operation in flight. req_ready = 0 from EXEC through RESP handshake.
- A request cannot be accepted in the same cycle as a response handshake; the earliest acceptance is the following cycle.
- rsp_zero is registered together with rsp_data.

Optional Feature:
ALU_SEQ_OVF_EN:
- Defined: adds output rsp_ovf (1 bit, reset 0), registered with rsp_data.
  - ADD/INC: set on signed overflow (operands same sign, result sign differs).
  - SUB/CMPEQ: set on signed overflow of A-B.
  - MUL: sticky across iterations on any signed-overflowing add.
  - 0 for NAND, PASSA, PASSB and error responses.
- Undefined: port absent; all other behaviour identical.

Decomposition:
- Package alu_seq_pkg holds:
  - ALU function constants (ADD 000, SUB 001, NAND 010, INC 011, PASSA 100, PASSB 101).
  - Request opcode enum including MUL and CMPEQ.
  - State enum.
- Natural sub-module: alu_seq_ovf_detect, a combinational signed-overflow check. It is instantiated only under ALU_SEQ_OVF_EN.
- The testbench instantiates the real ALU and connects it to alu_a/alu_b/alu_func/alu_out.

Test Plan:
- Reset, then ADD A=32'h7, B=32'h5 -> rsp_valid 2 cycles after accept, rsp_data=32'hC, rsp_zero=0.
- SUB A=B=32'h1234 -> rsp_data=0, rsp_zero=1. CMPEQ same operands -> rsp_data=1. CMPEQ A=3, B=4 -> rsp_data=0.
- MUL A=32'd13, B=32'd10 -> rsp_data=130 after 12 cycles. MUL B=0 -> rsp_data=0 in 2 cycles. MUL B=256 -> rsp_err=1, rsp_data=0.
- Hold rsp_ready=0 for 5 cycles after INC A=32'hFFFF_FFFF -> rsp_data=0 stable, rsp_zero=1, req_ready=0 throughout. Next request accepted the cycle after the handshake.
- Assert rst_n=0 during MUL_LOOP (A=5, B=100) -> immediate IDLE, req_ready=1, rsp_valid=0, alu_func=100.
- With ALU_SEQ_OVF_EN: ADD 32'h7FFF_FFFF+1 -> rsp_ovf=1. SUB 32'h8000_0000-1 -> rsp_ovf=1. NAND -> rsp_ovf=0.
